// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forward selects,
// result-source codes and the memory-wait FSM state type.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;
    localparam logic [1:0] RES_LOAD = 2'b01;

    typedef enum logic {
        HZ_RUN      = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_t;

    // Memory stage is newer than writeback, so its result wins.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
            return FWD_M;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module hz_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use / redirect / memory-wait
// stall and flush generation, memory-wait timeout and activity counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             mem_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WW = $clog2(TIMEOUT) + 1;

    hz_state_t   state;
    logic [WW-1:0] wait_cnt;
    logic        load_use;
    logic        mem_wait;
    logic        abort;

    assign abort    = (state == HZ_MEM_WAIT) && (wait_cnt == WW'(TIMEOUT - 1));
    assign mem_wait = MemReqM && !mem_ready && !abort;
    assign load_use = (ResultSrcE == RES_LOAD) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (rst) begin
            // Keep bubbles flowing into D and E while the core is held in reset.
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else begin
            ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
            ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
            if (mem_wait) begin
                // Freeze everything, including E, so a pending redirect survives.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HZ_RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else if (state == HZ_RUN) begin
            if (mem_wait) begin
                state    <= HZ_MEM_WAIT;
                wait_cnt <= WW'(1);
            end
        end else begin
            if (mem_ready || !MemReqM) begin
                state    <= HZ_RUN;
                wait_cnt <= '0;
            end else if (abort) begin
                state    <= HZ_RUN;
                wait_cnt <= '0;
                mem_err  <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + WW'(1);
            end
        end
    end

    hz_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (StallF),
        .cnt (stall_cnt)
    );

    hz_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (FlushD),
        .cnt (flush_cnt)
    );

endmodule
